// File: rtl/census_window_3x3.sv
// 3x3 census transform over a raster pixel stream: two line delays feed a
// sliding window, and each interior centre yields an 8-bit neighbour<centre signature.
module census_window_3x3 #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_pixel,
  output logic             out_valid,
  output logic [7:0]       out_census,
  output logic [XW-1:0]    out_x,
  output logic [YW-1:0]    out_y,
  output logic             out_eof
);

  localparam logic [XW-1:0] XMAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_H - 1);

  logic                        accept;
  logic [XW-1:0]               x, pos_x;
  logic [YW-1:0]               y, pos_y;
  logic [IMG_W-1:0][WIDTH-1:0] lb1, lb2;
  logic [WIDTH-1:0]            tap1, tap2;
  logic [2:0][2:0][WIDTH-1:0]  win;
  logic [7:0][WIDTH-1:0]       nb;
  logic [WIDTH-1:0]            centre;
  logic [7:0]                  census_n;
  logic                        win_ok, last;

  assign accept = en & in_valid;
  // sof overrides the counters so the current pixel is (0,0)
  assign pos_x  = in_sof ? '0 : x;
  assign pos_y  = in_sof ? '0 : y;
  assign tap1   = lb1[IMG_W-1];
  assign tap2   = lb2[IMG_W-1];
  assign win_ok = (pos_x >= XW'(2)) && (pos_y >= YW'(2));
  assign last   = (pos_x == XMAX) && (pos_y == YMAX);

  // Census is taken from the window as it will look after this accept's shift:
  // centre is the current newest middle-row pixel, right column comes from the inputs.
  assign centre = win[1][2];
  assign nb = {win[0][1], win[0][2], tap2,
               win[1][1],            tap1,
               win[2][1], win[2][2], in_pixel};

  for (genvar b = 0; b < 8; b++) begin : g_cmp
    assign census_n[b] = nb[b] < centre;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x   <= '0;
      y   <= '0;
      lb1 <= '0;
      lb2 <= '0;
      win <= '0;
    end else if (accept) begin
      if (pos_x == XMAX) begin
        x <= '0;
        y <= (pos_y == YMAX) ? '0 : pos_y + YW'(1);
      end else begin
        x <= pos_x + XW'(1);
        y <= pos_y;
      end
      lb1    <= {lb1[IMG_W-2:0], in_pixel};
      lb2    <= {lb2[IMG_W-2:0], tap1};
      win[0] <= {tap2,     win[0][2:1]};
      win[1] <= {tap1,     win[1][2:1]};
      win[2] <= {in_pixel, win[2][2:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_eof    <= 1'b0;
      out_census <= '0;
      out_x      <= '0;
      out_y      <= '0;
    end else begin
      out_valid <= accept & win_ok;
      out_eof   <= accept & win_ok & last;
      if (accept && win_ok) begin
        out_census <= census_n;
        out_x      <= pos_x - XW'(1);
        out_y      <= pos_y - YW'(1);
      end
    end
  end

endmodule

// File: tb/tb_census_window_3x3.sv
// Scoreboard bench for census_window_3x3: a frame-image model predicts each
// census output and a negedge monitor checks value and one-cycle latency.
module tb_census_window_3x3;
  localparam int W = 5;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
  logic [7:0] in_pixel = '0;
  logic       out_valid, out_eof;
  logic [7:0] out_census;
  logic [2:0] out_x;
  logic [1:0] out_y;

  census_window_3x3 #(.WIDTH(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_sof(in_sof),
    .in_pixel(in_pixel), .out_valid(out_valid), .out_census(out_census),
    .out_x(out_x), .out_y(out_y), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] c;
    int         x;
    int         y;
    bit         eof;
    int         due;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   mx = 0, my = 0;
  int   img[H][W];
  int   eofs_seen = 0, eofs_exp = 0;

  function automatic logic [7:0] ref_census(int cx, int cy);
    logic [7:0] r;
    int b;
    r = '0;
    b = 7;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (!(dx == 0 && dy == 0)) begin
          r[b] = img[cy+dy][cx+dx] < img[cy][cx];
          b--;
        end
    return r;
  endfunction

  task automatic model_accept(int pix, bit sof);
    exp_t e;
    int px, py;
    px = sof ? 0 : mx;
    py = sof ? 0 : my;
    img[py][px] = pix;
    if (px >= 2 && py >= 2) begin
      e.c   = ref_census(px - 1, py - 1);
      e.x   = px - 1;
      e.y   = py - 1;
      e.eof = (px == W - 1) && (py == H - 1);
      e.due = cyc + 1;
      if (e.eof) eofs_exp++;
      q.push_back(e);
    end
    mx = (px + 1) % W;
    my = (px == W - 1) ? (py + 1) % H : py;
  endtask

  task automatic cycle(bit e, bit v, int pix, bit sof);
    @(posedge clk);
    #1;
    en       = e;
    in_valid = v;
    in_pixel = 8'(pix);
    in_sof   = sof;
    if (e && v) model_accept(pix & 8'hFF, sof);
  endtask

  task automatic send(int pix, bit sof, bit gappy);
    bit e;
    if (gappy)
      repeat ($urandom_range(0, 2)) begin
        e = 1'($urandom_range(0, 1));
        cycle(e, e ? 1'b0 : 1'($urandom_range(0, 1)), $urandom_range(0, 255),
              1'($urandom_range(0, 1)));
      end
    cycle(1'b1, 1'b1, pix, sof);
  endtask

  function automatic int pix_of(int kind, int x, int y);
    if (kind == 0) return y * W + x;
    if (kind == 1) return 8'h40;
    return int'($urandom_range(0, 255));
  endfunction

  task automatic frame(int kind, bit gappy, int npix);
    for (int i = 0; i < npix; i++)
      send(pix_of(kind, i % W, i / W), i == 0, gappy);
  endtask

  task automatic idle(int n);
    repeat (n) cycle(1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_eof"}, int'(out_eof), 0);
    chk({tag, "_census"}, int'(out_census), 0);
    chk({tag, "_x"}, int'(out_x), 0);
    chk({tag, "_y"}, int'(out_y), 0);
  endtask

  // Monitor: every out_valid must match the head of the queue on its due cycle
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (out_valid) begin
        checks++;
        if (out_eof) eofs_seen++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: census=%h x=%0d y=%0d at cycle %0d",
                   out_census, out_x, out_y, cyc);
        end else begin
          e = q.pop_front();
          if (out_census !== e.c || int'(out_x) != e.x || int'(out_y) != e.y ||
              out_eof !== e.eof || cyc != e.due) begin
            errors++;
            $display("FAIL output: got census=%h x=%0d y=%0d eof=%0b cyc=%0d expected census=%h x=%0d y=%0d eof=%0b cyc=%0d",
                     out_census, out_x, out_y, out_eof, cyc, e.c, e.x, e.y, e.eof, e.due);
          end
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_output: got out_valid=0 expected census=%h x=%0d y=%0d at cycle %0d",
                 e.c, e.x, e.y, e.due);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    frame(0, 1'b0, W * H); idle(2);   // ramp, continuous
    frame(1, 1'b0, W * H); idle(2);   // flat
    frame(0, 1'b1, W * H); idle(2);   // ramp with gaps and stalls
    frame(2, 1'b1, W * H); idle(2);   // random with gaps

    // asynchronous reset mid-frame
    frame(2, 1'b0, 13); idle(2);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_zero_outputs("async_rst");
    mx = 0; my = 0;
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    frame(0, 1'b0, W * H); idle(2);

    // sof arrives when counters are at (2,2)
    frame(0, 1'b0, 12);
    frame(2, 1'b0, W * H); idle(2);

    // back-to-back frames
    frame(2, 1'b0, W * H);
    frame(0, 1'b0, W * H);
    idle(3);

    chk("queue_drained", q.size(), 0);
    chk("eof_count", eofs_seen, eofs_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
